pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the CPU datapath, the generalised successor to the fixed-field stage registers. It carries a DATA_W-bit payload and a CTRL_W-bit control word through a 2-entry elastic buffer with valid/ready handshake. It also provides:
- hazard bubble insertion and synchronous flush;
- saturating stall and bubble performance counters.

It is instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- DATA_W, 64: payload width (PC, operands, immediates, register numbers).
- CTRL_W, 10: control-word width (RegWr, MemWr, ALUctr, ...).
- CTRL_BUBBLE, {CTRL_W{1'b0}}: control value presented whenever the stage is empty (NOP encoding).
- DATA_CLR_ON_BUBBLE, 0:
  - 1: out_data is forced to 0 when the stage empties.
  - 0: out_data holds its last value.
- CNT_W, 16: performance counter width.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control word.
- bubble  in  1  hazard: refuse input this cycle (upstream holds).
- flush  in  1  discard all held entries (branch/jump taken).
- out_valid  out  1  stage holds a valid entry.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control word; CTRL_BUBBLE when out_valid=0.
- occ  out  2  entries held (0, 1, 2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_W  cycles with bubble=1 and flush=0.
- clr_cnt  in  1  synchronous clear of both counters.

## Operation
- Transfers:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
- in_ready = Rst_n & ~flush & ~bubble & (occ != 2).
  - Depends only on registered occ and on bubble/flush.
  - It has no combinational path from out_ready.
- Storage: head register (main) and skid register; order is strictly preserved.
- State occ, transitions (flush=0):
  - 0: in_xfer → main<=in, occ=1.
  - 1, in_xfer & ~out_xfer → skid<=in, occ=2.
  - 1, in_xfer & out_xfer → main<=in, occ=1.
  - 1, ~in_xfer & out_xfer → occ=0.
  - 2, out_xfer → main<=skid, occ=1. No input is possible from occ=2.
  - Otherwise: hold.
- out_valid = (occ != 0).
- out_data/out_ctrl come from main when occ != 0; out_ctrl = CTRL_BUBBLE when occ=0.
- Bubble: no entry is accepted that cycle.
  - Downstream may still drain the stage, so an empty slot (NOP) propagates.
  - Held entries are never modified by bubble.
- Flush: occ<=0 on the next edge, regardless of in/out activity.
  - Any same-cycle in_valid is dropped (in_ready=0).
  - The head may still be consumed by downstream in the flush cycle.
  - If DATA_CLR_ON_BUBBLE=1, main data <= 0.
  - Flush has priority over bubble and all transitions.
- Emptying (occ→0 by drain or flush) with DATA_CLR_ON_BUBBLE=1 clears main data to 0.
- Counters:
  - Saturate at all-ones; no wrap.
  - clr_cnt has priority over increment: the counter reads 0 the next cycle even if its increment condition holds.
  - stall_cnt counts regardless of bubble/flush.

## Timing
- Reset (Rst_n low, asynchronous):
  - occ=0, out_valid=0.
  - out_ctrl=CTRL_BUBBLE, out_data=0.
  - stall_cnt=0, bubble_cnt=0, in_ready=0.
- in_ready rises combinationally once Rst_n is high, subject to bubble/flush.
- Reset asserted mid-operation drops all entries immediately.
- Latency: an entry accepted at edge N is on out_data/out_ctrl with out_valid=1 after edge N, i.e. visible in cycle N+1.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Back-pressure:
  - out_ready low for one cycle at occ=1 with input active → occ=2.
  - in_ready falls the cycle after.
  - No entry is lost or duplicated.
- Simultaneous events at occ=2:
  - out_xfer together with bubble → occ=1.
  - in_ready returns after the edge if bubble is deasserted.
- Counter values update on the edge following the counted cycle.

## Test plan
- Streaming: in_valid=1 with data 1..8, out_ready=1, no hazards.
  - out_data shows 1..8 on consecutive cycles, one cycle delayed.
  - occ stays 1; stall_cnt=0.
- Back-pressure: stream 1..6, out_ready=0 for cycles 3–5.
  - occ reaches 2; in_ready=0 while full.
  - Output order is exactly 1..6 with no duplicates.
  - stall_cnt=3.
- Bubble: bubble=1 for 2 cycles mid-stream, out_ready=1.
  - Two cycles with out_valid=0 and out_ctrl=CTRL_BUBBLE.
  - Upstream entry held, then delivered.
  - bubble_cnt=2.
- Flush at occ=2 with in_valid=1.
  - Next cycle occ=0, out_valid=0; the incoming entry is not captured.
  - With DATA_CLR_ON_BUBBLE=1, out_data=0.
- Counters: CNT_W=4, out_ready=0 for 20 cycles with a valid entry → stall_cnt saturates at 15.
  - clr_cnt asserted in the same cycle as a stall → stall_cnt=0 next cycle.
- Reset mid-stream at occ=2: Rst_n low → out_valid=0 and out_ctrl=CTRL_BUBBLE immediately, before any edge; counters 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg : 2-entry elastic pipeline register with bubble/flush + perf counters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg #(
   parameter int unsigned         DATA_W             = 64,
   parameter int unsigned         CTRL_W             = 10,
   parameter logic [CTRL_W-1:0]   CTRL_BUBBLE        = '0,
   parameter int unsigned         DATA_CLR_ON_BUBBLE = 0,
   parameter int unsigned         CNT_W              = 16
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              bubble,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt,
   input  logic              clr_cnt
);

   localparam logic [1:0] c_OCC_EMPTY = 2'd0;
   localparam logic [1:0] c_OCC_ONE   = 2'd1;
   localparam logic [1:0] c_OCC_FULL  = 2'd2;
   localparam bit         c_CLR_DATA  = (DATA_CLR_ON_BUBBLE != 0);

   logic [1:0]        occ_q,        occ_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
   logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
   logic              in_xfer;
   logic              out_xfer;

   // in_ready sees only registered occupancy, never out_ready
   assign in_ready  = Rst_n & ~flush & ~bubble & (occ_q != c_OCC_FULL);
   assign out_valid = (occ_q != c_OCC_EMPTY);
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   assign out_data   = main_data_q;
   assign out_ctrl   = out_valid ? main_ctrl_q : CTRL_BUBBLE;
   assign occ        = occ_q;
   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;

   always_comb begin
      occ_d       = occ_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         occ_d = c_OCC_EMPTY;
         if (c_CLR_DATA) main_data_d = '0;
      end else begin
         case (occ_q)
            c_OCC_EMPTY: begin
               if (in_xfer) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
                  occ_d       = c_OCC_ONE;
               end
            end
            c_OCC_ONE: begin
               if (in_xfer && !out_xfer) begin
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
                  occ_d       = c_OCC_FULL;
               end else if (in_xfer && out_xfer) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (out_xfer) begin
                  occ_d = c_OCC_EMPTY;
                  if (c_CLR_DATA) main_data_d = '0;
               end
            end
            c_OCC_FULL: begin
               if (out_xfer) begin
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  occ_d       = c_OCC_ONE;
               end
            end
            default: occ_d = c_OCC_EMPTY;
         endcase
      end
   end

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (clr_cnt) begin
         stall_cnt_d  = '0;
         bubble_cnt_d = '0;
      end else begin
         if (out_valid && !out_ready && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
         if (bubble && !flush && !(&bubble_cnt_q))
            bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         occ_q        <= c_OCC_EMPTY;
         main_data_q  <= '0;
         main_ctrl_q  <= '0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= '0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         occ_q        <= occ_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

endmodule

`default_nettype wire
